// File: rtl/aq_ifu_ras_ctrl.sv
// rtl/aq_ifu_ras_ctrl.sv - return-address-stack controller with speculative and retire stacks
// The speculative stack predicts returns at pre-decode; on flush it is rebuilt from the retire stack.
module aq_ifu_ras_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 40
) (
  input  logic          forever_cpuclk,
  input  logic          cpurst,
  input  logic          ipack_pred_inst0_vld,
  input  logic [AW-1:0] ipack_pred_pc,
  input  logic          pred_link_vld0,
  input  logic          pred_ret_vld0,
  input  logic          ifu_stall,
  input  logic          rtu_ras_link_vld,
  input  logic [AW-1:0] rtu_ras_link_addr,
  input  logic          rtu_ras_ret_vld,
  input  logic          rtu_ifu_flush,
  output logic          ras_pred_vld,
  output logic [AW-1:0] ras_pred_addr,
  output logic          ras_empty,
  output logic          ras_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [AW-1:0] spec_array [DEPTH];
  logic [AW-1:0] rtu_array  [DEPTH];
  logic [PW-1:0] spec_top, rtu_top;
  logic [CW-1:0] spec_cnt, rtu_cnt;

  logic          spec_upd, spec_push, spec_pop;
  logic [AW-1:0] link_addr;
  logic          spec_we, rtu_we;
  logic [PW-1:0] spec_widx, rtu_widx, spec_top_nxt, rtu_top_nxt;
  logic [CW-1:0] spec_cnt_nxt, rtu_cnt_nxt, spec_cnt_fin;

  assign spec_upd  = ipack_pred_inst0_vld & ~ifu_stall & ~rtu_ifu_flush;
  assign spec_push = spec_upd & pred_link_vld0;
  assign spec_pop  = spec_upd & pred_ret_vld0;
  assign link_addr = ipack_pred_pc + AW'(4);

  assign ras_pred_vld  = ipack_pred_inst0_vld & pred_ret_vld0 & (spec_cnt != '0);
  assign ras_pred_addr = ras_pred_vld ? spec_array[spec_top] : '0;

  // Push+pop on a non-empty stack replaces the top in place; on a full stack a push wraps over the oldest.
  always_comb begin
    spec_we      = 1'b0;
    spec_widx    = spec_top;
    spec_top_nxt = spec_top;
    spec_cnt_nxt = spec_cnt;
    if (spec_push && spec_pop && spec_cnt != '0) begin
      spec_we = 1'b1;
    end else if (spec_push) begin
      spec_we      = 1'b1;
      spec_widx    = spec_top + PW'(1);
      spec_top_nxt = spec_top + PW'(1);
      spec_cnt_nxt = (spec_cnt == CNT_MAX) ? CNT_MAX : spec_cnt + CW'(1);
    end else if (spec_pop && spec_cnt != '0) begin
      spec_top_nxt = spec_top - PW'(1);
      spec_cnt_nxt = spec_cnt - CW'(1);
    end
  end

  always_comb begin
    rtu_we      = 1'b0;
    rtu_widx    = rtu_top;
    rtu_top_nxt = rtu_top;
    rtu_cnt_nxt = rtu_cnt;
    if (rtu_ras_link_vld && rtu_ras_ret_vld && rtu_cnt != '0) begin
      rtu_we = 1'b1;
    end else if (rtu_ras_link_vld) begin
      rtu_we      = 1'b1;
      rtu_widx    = rtu_top + PW'(1);
      rtu_top_nxt = rtu_top + PW'(1);
      rtu_cnt_nxt = (rtu_cnt == CNT_MAX) ? CNT_MAX : rtu_cnt + CW'(1);
    end else if (rtu_ras_ret_vld && rtu_cnt != '0) begin
      rtu_top_nxt = rtu_top - PW'(1);
      rtu_cnt_nxt = rtu_cnt - CW'(1);
    end
  end

  assign spec_cnt_fin = rtu_ifu_flush ? rtu_cnt_nxt : spec_cnt_nxt;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int i = 0; i < DEPTH; i++) rtu_array[i] <= '0;
      rtu_top <= '0;
      rtu_cnt <= '0;
    end else begin
      if (rtu_we) rtu_array[rtu_widx] <= rtu_ras_link_addr;
      rtu_top <= rtu_top_nxt;
      rtu_cnt <= rtu_cnt_nxt;
    end
  end

  // Flush copies the retire stack including this cycle's retire write.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int i = 0; i < DEPTH; i++) spec_array[i] <= '0;
      spec_top  <= '0;
      spec_cnt  <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
    end else begin
      if (rtu_ifu_flush) begin
        for (int i = 0; i < DEPTH; i++)
          spec_array[i] <= (rtu_we && rtu_widx == PW'(i)) ? rtu_ras_link_addr : rtu_array[i];
        spec_top <= rtu_top_nxt;
      end else begin
        if (spec_we) spec_array[spec_widx] <= link_addr;
        spec_top <= spec_top_nxt;
      end
      spec_cnt  <= spec_cnt_fin;
      ras_empty <= (spec_cnt_fin == '0);
      ras_full  <= (spec_cnt_fin == CNT_MAX);
    end
  end
endmodule

// File: tb/tb_aq_ifu_ras_ctrl.sv
// tb/tb_aq_ifu_ras_ctrl.sv - self-checking bench for aq_ifu_ras_ctrl
// Stacks are modelled as bounded queues of return addresses.
module tb_aq_ifu_ras_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 40;
  typedef logic [AW-1:0] addr_t;
  typedef addr_t aq_t[$];

  logic  forever_cpuclk = 1'b0;
  logic  cpurst = 1'b1;
  logic  ipack_pred_inst0_vld = 1'b0;
  addr_t ipack_pred_pc = '0;
  logic  pred_link_vld0 = 1'b0, pred_ret_vld0 = 1'b0, ifu_stall = 1'b0;
  logic  rtu_ras_link_vld = 1'b0, rtu_ras_ret_vld = 1'b0, rtu_ifu_flush = 1'b0;
  addr_t rtu_ras_link_addr = '0;
  logic  ras_pred_vld, ras_empty, ras_full;
  addr_t ras_pred_addr;

  int n_chk = 0;
  int n_fail = 0;
  aq_t spec_q, ret_q;

  aq_ifu_ras_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
    .ipack_pred_inst0_vld(ipack_pred_inst0_vld), .ipack_pred_pc(ipack_pred_pc),
    .pred_link_vld0(pred_link_vld0), .pred_ret_vld0(pred_ret_vld0), .ifu_stall(ifu_stall),
    .rtu_ras_link_vld(rtu_ras_link_vld), .rtu_ras_link_addr(rtu_ras_link_addr),
    .rtu_ras_ret_vld(rtu_ras_ret_vld), .rtu_ifu_flush(rtu_ifu_flush),
    .ras_pred_vld(ras_pred_vld), .ras_pred_addr(ras_pred_addr),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic aq_t stack_upd(aq_t q, bit push, bit pop, addr_t a);
    aq_t r = q;
    if (push && pop && r.size() > 0) r[r.size()-1] = a;
    else if (push) begin
      r.push_back(a);
      if (r.size() > DEPTH) void'(r.pop_front());
    end else if (pop && r.size() > 0) void'(r.pop_back());
    return r;
  endfunction

  task automatic drive(input bit v, input addr_t pc, input bit lk, input bit rt, input bit st,
                       input bit rl, input addr_t ra, input bit rr, input bit fl);
    ipack_pred_inst0_vld = v; ipack_pred_pc = pc; pred_link_vld0 = lk; pred_ret_vld0 = rt;
    ifu_stall = st; rtu_ras_link_vld = rl; rtu_ras_link_addr = ra; rtu_ras_ret_vld = rr;
    rtu_ifu_flush = fl;
  endtask

  // Called at posedge+1 with inputs applied; returns at next posedge+1.
  task automatic cycle();
    bit    exp_vld;
    addr_t exp_addr;
    #4;
    exp_vld  = ipack_pred_inst0_vld && pred_ret_vld0 && spec_q.size() != 0;
    exp_addr = exp_vld ? spec_q[spec_q.size()-1] : '0;
    chk("pred_vld", 64'(ras_pred_vld), 64'(exp_vld));
    chk("pred_addr", 64'(ras_pred_addr), 64'(exp_addr));
    @(posedge forever_cpuclk);
    ret_q = stack_upd(ret_q, rtu_ras_link_vld, rtu_ras_ret_vld, rtu_ras_link_addr);
    if (rtu_ifu_flush) spec_q = ret_q;
    else if (ipack_pred_inst0_vld && !ifu_stall)
      spec_q = stack_upd(spec_q, pred_link_vld0, pred_ret_vld0, ipack_pred_pc + addr_t'(4));
    #1;
    chk("empty", 64'(ras_empty), 64'(spec_q.size() == 0));
    chk("full", 64'(ras_full), 64'(spec_q.size() == DEPTH));
  endtask

  task automatic call(input addr_t pc);
    drive(1, pc, 1, 0, 0, 0, '0, 0, 0); cycle();
  endtask

  task automatic ret();
    drive(1, '0, 0, 1, 0, 0, '0, 0, 0); cycle();
  endtask

  initial begin
    repeat (2) @(posedge forever_cpuclk);
    #1;
    chk("rst_empty", 64'(ras_empty), 64'd1);
    chk("rst_full", 64'(ras_full), 64'd0);
    chk("rst_pred_vld", 64'(ras_pred_vld), 64'd0);
    chk("rst_pred_addr", 64'(ras_pred_addr), 64'd0);
    cpurst = 1'b0;
    @(posedge forever_cpuclk); #1;

    // 1: return on empty stack
    ret();
    chk("t1_empty", 64'(ras_empty), 64'd1);
    // 2: call then return
    call(40'h1000);
    drive(1, '0, 0, 1, 0, 0, '0, 0, 0); #4;
    chk("t2_addr", 64'(ras_pred_addr), 64'h1004);
    #1; @(posedge forever_cpuclk); #1;
    spec_q = stack_upd(spec_q, 0, 1, '0);
    chk("t2_empty", 64'(ras_empty), 64'd1);
    // 3: overflow wraps over oldest
    for (int i = 1; i <= 9; i++) call(addr_t'(i * 'h100));
    chk("t3_full", 64'(ras_full), 64'd1);
    for (int i = 0; i < 9; i++) ret();
    // 4: stall freezes speculative state
    for (int i = 0; i < 3; i++) begin
      drive(1, 40'h4000, 1, 0, 1, 0, '0, 0, 0); cycle();
    end
    chk("t4_stall_empty", 64'(ras_empty), 64'd1);
    call(40'h4000);
    ret();
    chk("t4_single_push", 64'(ras_empty), 64'd1);
    // 5: flush restores from retire stack
    drive(0, '0, 0, 0, 0, 1, 40'hA004, 0, 0); cycle();
    call(40'hB000);
    call(40'hC000);
    drive(0, '0, 0, 0, 0, 0, '0, 0, 1); cycle();
    drive(1, '0, 0, 1, 0, 0, '0, 0, 0); #4;
    chk("t5_addr", 64'(ras_pred_addr), 64'hA004);
    #1; @(posedge forever_cpuclk); #1;
    spec_q = stack_upd(spec_q, 0, 1, '0);
    // 6: address wrap, push+pop, flush beats push
    call(40'hFF_FFFF_FFFC);
    call(40'h2000);
    drive(1, 40'h3000, 1, 1, 0, 0, '0, 0, 0); cycle();
    chk("t6_not_full", 64'(ras_full), 64'd0);
    drive(1, 40'h5000, 1, 0, 0, 0, '0, 0, 1); cycle();
    ret();
    ret();

    // randomized traffic with one asynchronous mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        drive(1, '0, 0, 1, 0, 1, 40'h77, 0, 1);
        cpurst = 1'b1; #1;
        chk("arst_empty", 64'(ras_empty), 64'd1);
        chk("arst_full", 64'(ras_full), 64'd0);
        chk("arst_pred_vld", 64'(ras_pred_vld), 64'd0);
        spec_q.delete(); ret_q.delete();
        @(posedge forever_cpuclk); #1;
        cpurst = 1'b0;
      end
      drive($urandom_range(0, 9) < 8, {$urandom, $urandom}, $urandom_range(0, 9) < 5,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 4,
            {$urandom, $urandom}, $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
